// File: rtl/inst_issue_buffer_if.sv
// Fetch/issue bundle for inst_issue_buffer.
//   master : fetch + id side (drives pc/inst/we/flush/stall, observes full and head outputs)
//   slave  : the buffer itself
// Signals:
//   pc_i, inst1_i, inst2_i, we1_i, we2_i : fetched pair, inst2 at pc_i+4
//   flush_i, stall_i                     : discard queue / hold head
//   full_o                               : fewer than two free entries
//   valid_o, issue_o                     : head issuable, dual(1)/single(0)
//   inst1_o, inst2_o, pc1_o, pc2_o       : head and head+1 entries
//   is_in_delayslot1_o/2_o               : delay-slot flags of the issued entries
interface inst_issue_buffer_if;
  logic [31:0] pc_i;
  logic [31:0] inst1_i;
  logic [31:0] inst2_i;
  logic        we1_i;
  logic        we2_i;
  logic        flush_i;
  logic        stall_i;
  logic        full_o;
  logic        valid_o;
  logic        issue_o;
  logic [31:0] inst1_o;
  logic [31:0] inst2_o;
  logic [31:0] pc1_o;
  logic [31:0] pc2_o;
  logic        is_in_delayslot1_o;
  logic        is_in_delayslot2_o;

  modport master (
    output pc_i, inst1_i, inst2_i, we1_i, we2_i, flush_i, stall_i,
    input  full_o, valid_o, issue_o, inst1_o, inst2_o, pc1_o, pc2_o,
           is_in_delayslot1_o, is_in_delayslot2_o
  );

  modport slave (
    input  pc_i, inst1_i, inst2_i, we1_i, we2_i, flush_i, stall_i,
    output full_o, valid_o, issue_o, inst1_o, inst2_o, pc1_o, pc2_o,
           is_in_delayslot1_o, is_in_delayslot2_o
  );
endinterface

// File: rtl/inst_issue_buffer.sv
// Circular instruction queue between icache fetch and the dual-issue id stage.
// Takes up to two instructions per cycle, presents the two oldest with pc and
// delay-slot flags plus a single/dual issue decision, and keeps every branch
// paired with its delay slot at issue.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : inst_issue_buffer_if.slave (fetch write side + id issue side)
module inst_issue_buffer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input logic                clk,
  input logic                rst,
  inst_issue_buffer_if.slave bus
);
  localparam int unsigned CNT_W        = ADDR_W + 1;
  localparam logic        DUAL_ISSUE   = 1'b1;
  localparam logic        SINGLE_ISSUE = 1'b0;

  logic [31:0]       inst_mem [DEPTH];
  logic [31:0]       pc_mem   [DEPTH];
  logic [DEPTH-1:0]  br_mem;
  logic [DEPTH-1:0]  ds_mem;

  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic [ADDR_W-1:0] head1;
  logic [ADDR_W-1:0] tail1;
  logic [CNT_W-1:0]  count;
  logic              last_br;

  logic              full_c;
  logic              wr_en;
  logic              wr_dual;
  logic              br1;
  logic              br2;
  logic              valid_c;
  logic              dual_c;
  logic [1:0]        n_wr;
  logic [1:0]        n_ret;

  // Branch/jump pre-decode: anything that owns a delay slot.
  function automatic logic is_branch(input logic [31:0] inst);
    logic [5:0] op;
    logic [4:0] rt;
    logic [5:0] funct;
    op    = inst[31:26];
    rt    = inst[20:16];
    funct = inst[5:0];
    case (op)
      6'h00:   is_branch = (funct == 6'h08) || (funct == 6'h09);
      6'h01:   is_branch = (rt == 5'h00) || (rt == 5'h01) ||
                           (rt == 5'h10) || (rt == 5'h11);
      6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07: is_branch = 1'b1;
      default: is_branch = 1'b0;
    endcase
  endfunction

  assign head1   = head + ADDR_W'(1);
  assign tail1   = tail + ADDR_W'(1);
  assign full_c  = (count >= CNT_W'(DEPTH - 1));
  assign wr_en   = !bus.flush_i && !full_c && bus.we1_i;
  assign wr_dual = wr_en && bus.we2_i;
  assign br1     = is_branch(bus.inst1_i);
  assign br2     = is_branch(bus.inst2_i);
  assign n_wr    = wr_en ? (wr_dual ? 2'd2 : 2'd1) : 2'd0;
  assign n_ret   = (valid_c && !bus.stall_i) ? (dual_c ? 2'd2 : 2'd1) : 2'd0;

  // Issue decision: a lone branch at the head waits for its delay slot.
  always_comb begin
    valid_c = 1'b0;
    dual_c  = 1'b0;
    if (count >= CNT_W'(2)) begin
      valid_c = 1'b1;
      dual_c  = br_mem[head] || !br_mem[head1];
    end else if (count == CNT_W'(1)) begin
      valid_c = !br_mem[head];
    end
  end

  // Head outputs, zeroed for slots that are not issued.
  always_comb begin
    bus.full_o             = full_c;
    bus.valid_o            = valid_c;
    bus.issue_o            = dual_c ? DUAL_ISSUE : SINGLE_ISSUE;
    bus.inst1_o            = 32'd0;
    bus.pc1_o              = 32'd0;
    bus.is_in_delayslot1_o = 1'b0;
    bus.inst2_o            = 32'd0;
    bus.pc2_o              = 32'd0;
    bus.is_in_delayslot2_o = 1'b0;
    if (valid_c) begin
      bus.inst1_o            = inst_mem[head];
      bus.pc1_o              = pc_mem[head];
      bus.is_in_delayslot1_o = ds_mem[head];
    end
    if (dual_c) begin
      bus.inst2_o            = inst_mem[head1];
      bus.pc2_o              = pc_mem[head1];
      bus.is_in_delayslot2_o = ds_mem[head1];
    end
  end

  // Entry storage; contents are only observed through count-qualified reads.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      inst_mem[tail] <= bus.inst1_i;
      pc_mem[tail]   <= bus.pc_i;
      br_mem[tail]   <= br1;
      ds_mem[tail]   <= last_br;
    end
    if (wr_dual) begin
      inst_mem[tail1] <= bus.inst2_i;
      pc_mem[tail1]   <= bus.pc_i + 32'd4;
      br_mem[tail1]   <= br2;
      ds_mem[tail1]   <= br1;
    end
  end

  // Pointers, occupancy and the branch-carry flag; flush overrides everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      last_br <= 1'b0;
    end else if (bus.flush_i) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      last_br <= 1'b0;
    end else begin
      head  <= head + ADDR_W'(n_ret);
      tail  <= tail + ADDR_W'(n_wr);
      count <= count + CNT_W'(n_wr) - CNT_W'(n_ret);
      if (wr_en) begin
        last_br <= wr_dual ? br2 : br1;
      end
    end
  end
endmodule

// File: tb/tb_inst_issue_buffer.sv
// Directed bench for inst_issue_buffer: reset, pairing, branch/delay-slot
// handling, full/wrap streaming, flush and stall.
module tb_inst_issue_buffer;
  localparam logic [31:0] ADDU   = 32'h0043_0821;
  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] BEQ    = 32'h1000_0003;
  localparam logic [31:0] BNE    = 32'h1400_0003;
  localparam logic [31:0] JR     = 32'h03E0_0008;
  localparam logic [31:0] BLTZAL = 32'h0410_0004;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  inst_issue_buffer_if bus ();

  inst_issue_buffer #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] i1, input logic [31:0] i2,
                       input logic w1, input logic w2);
    bus.pc_i    = pc;
    bus.inst1_i = i1;
    bus.inst2_i = i2;
    bus.we1_i   = w1;
    bus.we2_i   = w2;
  endtask

  task automatic idle();
    bus.we1_i = 1'b0;
    bus.we2_i = 1'b0;
  endtask

  logic [31:0] exp_pc;
  logic [31:0] wr_pc;
  int          issued;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(32'd0, NOP, NOP, 1'b0, 1'b0);
    bus.flush_i = 1'b0;
    bus.stall_i = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_full", 32'(bus.full_o), 32'd0);
    chk("rst_issue", 32'(bus.issue_o), 32'd0);
    chk("rst_inst1", bus.inst1_o, 32'd0);
    chk("rst_pc2", bus.pc2_o, 32'd0);
    @(negedge clk) rst = 1'b1;
    cyc();

    // Plain pair goes out together
    drive(32'h1000, ADDU, ADDU, 1'b1, 1'b1);
    cyc(); idle();
    chk("pair_valid", 32'(bus.valid_o), 32'd1);
    chk("pair_issue", 32'(bus.issue_o), 32'd1);
    chk("pair_pc1", bus.pc1_o, 32'h1000);
    chk("pair_pc2", bus.pc2_o, 32'h1004);
    chk("pair_inst2", bus.inst2_o, ADDU);
    chk("pair_ds2", 32'(bus.is_in_delayslot2_o), 32'd0);
    cyc();
    chk("pair_drained", 32'(bus.valid_o), 32'd0);

    // Branch in second slot is split from the ALU op and waits for its slot
    drive(32'h0, ADDU, BEQ, 1'b1, 1'b1);
    cyc(); idle();
    chk("split_valid", 32'(bus.valid_o), 32'd1);
    chk("split_issue", 32'(bus.issue_o), 32'd0);
    chk("split_pc1", bus.pc1_o, 32'h0);
    chk("split_inst2", bus.inst2_o, 32'd0);
    chk("split_pc2", bus.pc2_o, 32'd0);
    cyc();
    chk("br_wait_valid", 32'(bus.valid_o), 32'd0);
    chk("br_wait_inst1", bus.inst1_o, 32'd0);
    drive(32'h8, NOP, NOP, 1'b1, 1'b0);
    cyc(); idle();
    chk("br_ds_valid", 32'(bus.valid_o), 32'd1);
    chk("br_ds_issue", 32'(bus.issue_o), 32'd1);
    chk("br_ds_pc1", bus.pc1_o, 32'h4);
    chk("br_ds_pc2", bus.pc2_o, 32'h8);
    chk("br_ds_inst1", bus.inst1_o, BEQ);
    chk("br_ds_flag2", 32'(bus.is_in_delayslot2_o), 32'd1);
    chk("br_ds_flag1", 32'(bus.is_in_delayslot1_o), 32'd0);
    cyc();

    // Asynchronous reset in the middle of traffic
    bus.stall_i = 1'b1;
    drive(32'h2000, ADDU, ADDU, 1'b1, 1'b1); cyc();
    drive(32'h2008, ADDU, ADDU, 1'b1, 1'b1); cyc();
    drive(32'h2010, ADDU, ADDU, 1'b1, 1'b0); cyc();
    idle();
    chk("mid_count", 32'(dut.count), 32'd5);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.valid_o), 32'd0);
    chk("mid_rst_full", 32'(bus.full_o), 32'd0);
    chk("mid_rst_inst1", bus.inst1_o, 32'd0);
    @(negedge clk) rst = 1'b1;
    bus.stall_i = 1'b0;
    cyc();
    chk("post_rst_count", 32'(dut.count), 32'd0);
    chk("post_rst_valid", 32'(bus.valid_o), 32'd0);

    // Fill under stall, check full threshold and the dropped ninth pair
    bus.stall_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(32'h4000 + 32'(8 * i), ADDU, ADDU, 1'b1, 1'b1);
      cyc();
      chk("fill_count", 32'(dut.count), (i >= 7) ? 32'd16 : 32'(2 * (i + 1)));
      chk("fill_full", 32'(bus.full_o), (i >= 7) ? 32'd1 : 32'd0);
    end
    idle();
    chk("fill_head_pc", bus.pc1_o, 32'h4000);
    bus.stall_i = 1'b0;
    exp_pc = 32'h4000;
    wr_pc  = 32'h4040;
    issued = 0;
    for (int c = 0; c < 200 && issued < 40; c++) begin
      if (bus.valid_o) begin
        chk("stream_pc1", bus.pc1_o, exp_pc);
        exp_pc += 32'd4;
        issued++;
        if (bus.issue_o) begin
          chk("stream_pc2", bus.pc2_o, exp_pc);
          exp_pc += 32'd4;
          issued++;
        end
      end
      if (!bus.full_o && wr_pc < 32'h40A0) begin
        drive(wr_pc, ADDU, ADDU, 1'b1, 1'b1);
        wr_pc += 32'd8;
      end else begin
        idle();
      end
      cyc();
    end
    idle();
    chk("stream_issued", 32'(issued), 32'd40);
    chk("stream_empty", 32'(dut.count), 32'd0);

    // Flush beats same-cycle writes and clears the branch carry
    bus.stall_i = 1'b1;
    drive(32'h5000, ADDU, ADDU, 1'b1, 1'b1); cyc();
    drive(32'h5008, ADDU, ADDU, 1'b1, 1'b1); cyc();
    drive(32'h5010, ADDU, BEQ, 1'b1, 1'b1);  cyc();
    chk("pre_flush_count", 32'(dut.count), 32'd6);
    drive(32'h5018, ADDU, ADDU, 1'b1, 1'b1);
    bus.flush_i = 1'b1;
    cyc();
    bus.flush_i = 1'b0;
    idle();
    chk("flush_valid", 32'(bus.valid_o), 32'd0);
    chk("flush_count", 32'(dut.count), 32'd0);
    bus.stall_i = 1'b0;
    drive(32'h6000, ADDU, NOP, 1'b1, 1'b0);
    cyc(); idle();
    chk("post_flush_valid", 32'(bus.valid_o), 32'd1);
    chk("post_flush_pc1", bus.pc1_o, 32'h6000);
    chk("post_flush_ds1", 32'(bus.is_in_delayslot1_o), 32'd0);
    cyc();

    // Stall holds the head while the queue keeps its contents
    bus.stall_i = 1'b1;
    drive(32'h7000, ADDU, ADDU, 1'b1, 1'b1); cyc();
    drive(32'h7008, ADDU, ADDU, 1'b1, 1'b1); cyc();
    idle();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_pc1", bus.pc1_o, 32'h7000);
      chk("stall_inst1", bus.inst1_o, ADDU);
      chk("stall_count", 32'(dut.count), 32'd4);
    end
    bus.stall_i = 1'b0;
    cyc();
    chk("unstall_pc1", bus.pc1_o, 32'h7008);
    chk("unstall_count", 32'(dut.count), 32'd2);
    cyc();
    chk("unstall_empty", 32'(dut.count), 32'd0);

    // JR and REGIMM branch decode
    drive(32'h8000, ADDU, JR, 1'b1, 1'b1);
    cyc(); idle();
    chk("jr_split_issue", 32'(bus.issue_o), 32'd0);
    chk("jr_split_pc1", bus.pc1_o, 32'h8000);
    cyc();
    chk("jr_wait", 32'(bus.valid_o), 32'd0);
    drive(32'h8008, NOP, BLTZAL, 1'b1, 1'b1);
    cyc(); idle();
    chk("jr_ds_issue", 32'(bus.issue_o), 32'd1);
    chk("jr_ds_pc1", bus.pc1_o, 32'h8004);
    chk("jr_ds_flag2", 32'(bus.is_in_delayslot2_o), 32'd1);
    cyc();
    chk("bltzal_wait", 32'(bus.valid_o), 32'd0);
    drive(32'h8010, NOP, NOP, 1'b1, 1'b0);
    cyc(); idle();
    chk("bltzal_pc1", bus.pc1_o, 32'h800C);
    chk("bltzal_ds2", 32'(bus.is_in_delayslot2_o), 32'd1);
    cyc();

    // Branch in a delay slot: its own delay slot issues with flag1 set
    bus.stall_i = 1'b1;
    drive(32'h9000, BEQ, BNE, 1'b1, 1'b1); cyc();
    drive(32'h9008, NOP, NOP, 1'b1, 1'b0); cyc();
    idle();
    bus.stall_i = 1'b0;
    chk("bb_issue", 32'(bus.issue_o), 32'd1);
    chk("bb_ds1", 32'(bus.is_in_delayslot1_o), 32'd0);
    chk("bb_ds2", 32'(bus.is_in_delayslot2_o), 32'd1);
    cyc();
    chk("bb_tail_pc1", bus.pc1_o, 32'h9008);
    chk("bb_tail_issue", 32'(bus.issue_o), 32'd0);
    chk("bb_tail_ds1", 32'(bus.is_in_delayslot1_o), 32'd1);
    cyc();
    chk("bb_empty", 32'(dut.count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
